seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
Multi-cycle restoring divider that reverses the product path. It takes an 8-bit dividend (for example the output of the 4x4 multiplier) and a 4-bit divisor, and returns an 8-bit quotient, a 4-bit remainder and a divide-by-zero flag. It produces one quotient bit per clock. Operands enter and results leave through valid/ready handshakes, so the block sits between operand registers and the ALU result mux.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width; equals the number of CALC cycles.
- DIVISOR_W, 4, divisor and remainder width.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- in_valid  input  1  operands on dividend/divisor are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- dividend  input  DIVIDEND_W  unsigned dividend.
- divisor  input  DIVISOR_W  unsigned divisor.
- out_valid  output  1  result outputs are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- quotient  output  DIVIDEND_W  unsigned quotient.
- remainder  output  DIVISOR_W  unsigned remainder.
- div_by_zero  output  1  result came from a zero divisor.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
  - All internal registers cleared.
- States:
  - IDLE: in_ready=1.
    - in_valid&in_ready at an edge latches dividend and divisor (acceptance edge E0).
    - divisor==0: go to DONE with quotient=0, remainder=0, div_by_zero=1.
    - Otherwise: clear the partial remainder (DIVISOR_W+1 bits), load a bit counter with DIVIDEND_W, go to CALC.
  - CALC: in_ready=0, out_valid=0. Each edge does one restoring step:
    - Shift the partial remainder left, bringing in the dividend MSB.
    - Shift the dividend register left.
    - If partial remainder >= divisor: subtract the divisor and shift 1 into the quotient.
    - Else: shift 0 into the quotient.
    - Decrement the counter.
    - After the DIVIDEND_W-th step, go to DONE.
  - DONE: out_valid=1.
    - quotient, remainder and div_by_zero are stable and held for as long as out_ready=0.
    - An edge with out_ready=1 returns to IDLE. out_valid drops and in_ready rises at that edge.
- Latency:
  - Nonzero divisor: out_valid high from edge E0+DIVIDEND_W (8 edges).
  - Zero divisor: out_valid high from edge E0+1.
- Throughput: no overlap. A new operand can be accepted at the earliest one edge after result handoff, giving a minimum of DIVIDEND_W+2 cycles per operation.
- Outputs from DONE are held unchanged until the next result is loaded.
- Arithmetic:
  - Internal partial remainder is DIVISOR_W+1 bits so the compare never overflows.
  - Final remainder < divisor always fits in DIVISOR_W bits.
  - Quotient = floor(dividend/divisor). Quotient can reach 255 when divisor=1.
- Inputs:
  - in_valid while not in IDLE is ignored.
  - Operand changes after E0 do not affect the operation in flight.
- out_ready: while not in DONE it is ignored.
- Reset mid-operation: asserting reset in CALC or DONE aborts the operation. All outputs return to reset values and no result is emitted.
- div_by_zero clears on the next nonzero-divisor result.

Test Plan:
- 200/7 with out_ready=1 -> out_valid exactly 8 edges after acceptance; quotient=28, remainder=4, div_by_zero=0; in_ready=0 throughout CALC.
- 225/15 and 255/1 -> 15 r0, then 255 r0; checks full-width quotient and back-to-back gap of one IDLE cycle.
- 13/0 -> out_valid at E0+1; quotient=0, remainder=0, div_by_zero=1. Following 9/3 -> 3 r0 with div_by_zero=0.
- 5/9 -> quotient=0, remainder=5. Then hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, in_valid pulses ignored.
- Start 100/3, then pull reset low asynchronously mid-cycle at the 4th CALC cycle -> outputs go to reset values immediately, no out_valid. After release, 100/3 -> 33 r1.
- Random sweep of all 256x16 operand pairs -> match the combinational divide reference (0/0 for a zero divisor).

Source files
------------

// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
//
// Multi-cycle unsigned restoring divider. An 8-bit dividend (typically the
// product coming out of the 4x4 multiplier) is divided by a 4-bit divisor.
// One quotient bit is produced per clock. Operands enter and results leave
// through valid/ready handshakes. Only one operation is in flight at a time.
//
// Ports
//   clock        rising-edge clock for all state
//   reset        asynchronous, active-low reset
//   in_valid     operands on dividend/divisor are valid
//   in_ready     block can accept operands (high only while idle)
//   dividend     unsigned dividend, DIVIDEND_W bits
//   divisor      unsigned divisor, DIVISOR_W bits
//   out_valid    quotient/remainder/div_by_zero are valid (high only when done)
//   out_ready    consumer takes the result
//   quotient     floor(dividend / divisor), DIVIDEND_W bits
//   remainder    dividend mod divisor, DIVISOR_W bits
//   div_by_zero  the current result came from a zero divisor
// ---------------------------------------------------------------------------
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  // The step counter has to hold the value DIVIDEND_W itself.
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;

  // workReg_q starts as the dividend. Every step its MSB moves into the
  // partial remainder and the new quotient bit enters at the LSB, so after
  // DIVIDEND_W steps it holds the complete quotient.
  logic [DIVIDEND_W-1:0]  workReg_q;
  logic [DIVISOR_W-1:0]   divisor_q;
  logic [DIVISOR_W-1:0]   partialRem_q;
  logic [CNT_W-1:0]       count_q;

  // Result registers. They keep the last result until the next one lands.
  logic [DIVIDEND_W-1:0]  quotient_q;
  logic [DIVISOR_W-1:0]   remainder_q;
  logic                   divByZero_q;
  logic                   inReady_q;
  logic                   outValid_q;

  // Combinational values for one restoring step.
  logic [DIVISOR_W:0]     remShift_d;
  logic                   fits_d;
  logic [DIVISOR_W-1:0]   partialRem_d;
  logic [DIVIDEND_W-1:0]  workReg_d;

  // One restoring step. The shifted partial remainder is one bit wider than
  // the divisor, so the trial compare cannot overflow. The stored remainder
  // only needs DIVISOR_W bits because it is always below the divisor after a
  // step. The subtraction can therefore be done in DIVISOR_W bits: the
  // dropped top bit is exactly the borrow that the compare already
  // accounted for.
  always_comb begin
    remShift_d   = {partialRem_q, workReg_q[DIVIDEND_W-1]};
    fits_d       = (remShift_d >= {1'b0, divisor_q});
    partialRem_d = remShift_d[DIVISOR_W-1:0];
    if (fits_d) begin
      partialRem_d = remShift_d[DIVISOR_W-1:0] - divisor_q;
    end
    workReg_d    = {workReg_q[DIVIDEND_W-2:0], fits_d};
  end

  // Control FSM, datapath registers and registered handshake outputs.
  // A zero divisor still spends one cycle in CALC. That gives the
  // divide-by-zero result one cycle of latency after acceptance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      workReg_q    <= '0;
      divisor_q    <= '0;
      partialRem_q <= '0;
      count_q      <= '0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      divByZero_q  <= 1'b0;
      inReady_q    <= 1'b1;
      outValid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            workReg_q    <= dividend;
            divisor_q    <= divisor;
            partialRem_q <= '0;
            count_q      <= CNT_W'(DIVIDEND_W);
            inReady_q    <= 1'b0;
            state_q      <= CALC;
          end
        end

        CALC: begin
          if (divisor_q == '0) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b1;
            outValid_q  <= 1'b1;
            state_q     <= DONE;
          end else begin
            workReg_q    <= workReg_d;
            partialRem_q <= partialRem_d;
            count_q      <= count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
              quotient_q  <= workReg_d;
              remainder_q <= partialRem_d;
              divByZero_q <= 1'b0;
              outValid_q  <= 1'b1;
              state_q     <= DONE;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end

        default: begin
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = inReady_q;
  assign out_valid   = outValid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = divByZero_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_restoring_divider
//
// Directed and exhaustive checks of seq_restoring_divider. An expected result
// is queued whenever operands are accepted. It is popped and compared when
// out_valid rises.
// ---------------------------------------------------------------------------
module tb_seq_restoring_divider;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } result_t;

  result_t expQ[$];

  int testsRun    = 0;
  int failCount   = 0;
  int cycleCount  = 0;
  int e0          = 0;
  int lastHandoff = 0;

  seq_restoring_divider #(
    .DIVIDEND_W (8),
    .DIVISOR_W  (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count rising edges so latencies can be measured in edges.
  always @(posedge clock) cycleCount++;

  // Stop a run that hangs.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic result_t refDiv(input logic [7:0] a, input logic [3:0] b);
    result_t res;
    if (b == 4'd0) begin
      res.q   = 8'd0;
      res.r   = 4'd0;
      res.dbz = 1'b1;
    end else begin
      res.q   = a / {4'd0, b};
      res.r   = 4'(a % {4'd0, b});
      res.dbz = 1'b0;
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present one operand pair at a falling edge and wait for the accepting
  // rising edge. Afterwards the operand inputs are scrambled so that a
  // design that keeps reading them would produce wrong results.
  task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b);
    int waited = 0;
    while (in_ready !== 1'b1 && waited < 30) begin
      @(negedge clock);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    expQ.push_back(refDiv(a, b));
    @(negedge clock);
    e0       = cycleCount;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  // Wait for a result, check latency and value. Optionally stall the
  // consumer for holdCycles cycles while pulsing in_valid. Then hand the
  // result off.
  task automatic checkOutput(input int expLat, input int holdCycles);
    int      waited = 0;
    result_t exp;
    while (out_valid !== 1'b1 && waited < 20) begin
      check("in_ready_busy", 32'(in_ready), 32'd0);
      @(negedge clock);
      waited++;
    end
    if (out_valid !== 1'b1) begin
      check("result_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", 32'(cycleCount - e0), 32'(expLat));
    if (expQ.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    exp = expQ.pop_front();
    check("quotient", 32'(quotient), 32'(exp.q));
    check("remainder", 32'(remainder), 32'(exp.r));
    check("div_by_zero", 32'(div_by_zero), 32'(exp.dbz));
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < holdCycles; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      dividend  = 8'($urandom);
      divisor   = 4'($urandom);
      @(negedge clock);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_quotient", 32'(quotient), 32'(exp.q));
      check("hold_remainder", 32'(remainder), 32'(exp.r));
      check("hold_div_by_zero", 32'(div_by_zero), 32'(exp.dbz));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    lastHandoff = cycleCount;
    check("handoff_out_valid", 32'(out_valid), 32'd0);
    check("handoff_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 8'd0;
    divisor   = 4'd0;

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // 200/7 with out_ready already high during CALC.
    out_ready = 1'b1;
    applyStimulus(8'd200, 4'd7);
    checkOutput(8, 0);

    // Full-width quotient, issued back-to-back.
    applyStimulus(8'd225, 4'd15);
    checkOutput(8, 0);
    applyStimulus(8'd255, 4'd1);
    check("b2b_gap", 32'(e0 - lastHandoff), 32'd1);
    checkOutput(8, 0);

    // Zero divisor, then a nonzero divisor clears the flag.
    applyStimulus(8'd13, 4'd0);
    checkOutput(1, 0);
    applyStimulus(8'd9, 4'd3);
    checkOutput(8, 0);

    // Dividend below the divisor, with the consumer stalling.
    applyStimulus(8'd5, 4'd9);
    checkOutput(8, 5);

    // Asynchronous reset during the fourth CALC cycle.
    applyStimulus(8'd100, 4'd3);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_div_by_zero", 32'(div_by_zero), 32'd0);
    void'(expQ.pop_front());
    repeat (2) begin
      @(negedge clock);
      check("abort_no_result", 32'(out_valid), 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);
    applyStimulus(8'd100, 4'd3);
    checkOutput(8, 0);

    // Every operand pair.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(8'(a), 4'(b));
        checkOutput((b == 0) ? 1 : 8, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
